// File: rtl/ping_pong_seven_seg_display.sv
// Purpose: scans the ping-pong counter value and direction onto a 4-digit active-low display.
// Latency: an/seg register one cycle after idx and the holding registers; a sample shows 2 edges after sample_en.
// Backpressure: none; sample_en is a free-running capture strobe and the scan never stalls.
module ping_pong_seven_seg_display #(
    parameter int REFRESH_DIV = 131072,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [3:0] value,
    input  logic       dir,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_UP    = 7'b1011100;
    localparam logic [6:0] SEG_DOWN  = 7'b1100011;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       idx;
    logic [3:0]       val_q;
    logic             dir_q;

    logic             tens;
    logic [3:0]       ones;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Values only reach 15, so the BCD split is a single compare-and-subtract.
    always_comb begin
        tens    = (val_q >= 4'd10);
        ones    = tens ? (val_q - 4'd10) : val_q;
        an_nxt  = ~(4'b0001 << idx);
        seg_nxt = SEG_BLANK;
        case (idx)
            2'd0:    seg_nxt = digit_seg(ones);
            2'd1:    seg_nxt = tens ? SEG_ONE : SEG_BLANK;
            default: seg_nxt = dir_q ? SEG_UP : SEG_DOWN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            val_q       <= 4'd0;
            dir_q       <= 1'b1;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                idx         <= idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end

            if (sample_en) begin
                val_q <= value;
                dir_q <= dir;
            end

            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_ping_pong_seven_seg_display.sv
module tb_ping_pong_seven_seg_display;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] UP    = 7'b1011100;
    localparam logic [6:0] DOWN  = 7'b1100011;

    logic       clk;
    logic       rst_n;
    logic       sample_en;
    logic [3:0] value;
    logic       dir;
    logic [3:0] an;
    logic [6:0] seg;

    int errors = 0;
    int checks = 0;

    logic [3:0] an_tab  [4];
    logic [6:0] seg_tab [4];

    ping_pong_seven_seg_display #(
        .REFRESH_DIV(4),
        .CNT_W      (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(sample_en),
        .value    (value),
        .dir      (dir),
        .an       (an),
        .seg      (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset is released at a negedge, so the next posedge is post-reset edge 1.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sample_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; sample_en = 1'b0; value = 4'd9; dir = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an_async got=%b want=1111", an); end
        checks++; if (seg !== BLANK)  begin errors++; $display("FAIL reset_seg_async got=%b want=%b", seg, BLANK); end
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an_held got=%b want=1111", an); end
        checks++; if (seg !== BLANK)  begin errors++; $display("FAIL reset_seg_held got=%b want=%b", seg, BLANK); end
        rst_n = 1'b1;
        seg_tab[0] = S0; seg_tab[1] = BLANK; seg_tab[2] = UP; seg_tab[3] = UP;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            checks++; if (an !== an_tab[((e-1)/4)%4]) begin errors++; $display("FAIL reset_scan_an edge=%0d got=%b want=%b", e, an, an_tab[((e-1)/4)%4]); end
            checks++; if (seg !== seg_tab[((e-1)/4)%4]) begin errors++; $display("FAIL reset_scan_seg edge=%0d got=%b want=%b", e, seg, seg_tab[((e-1)/4)%4]); end
        end
    endtask

    task automatic test_sample_up();
        do_reset();
        sample_en = 1'b1; value = 4'd13; dir = 1'b1;
        @(negedge clk);
        sample_en = 1'b0; value = 4'd0; dir = 1'b0;
        checks++; if (seg !== S0) begin errors++; $display("FAIL up_first_seg got=%b want=%b", seg, S0); end
        seg_tab[0] = S3; seg_tab[1] = S1; seg_tab[2] = UP; seg_tab[3] = UP;
        for (int e = 2; e <= 17; e++) begin
            @(negedge clk);
            checks++; if (an !== an_tab[((e-1)/4)%4]) begin errors++; $display("FAIL up_an edge=%0d got=%b want=%b", e, an, an_tab[((e-1)/4)%4]); end
            checks++; if (seg !== seg_tab[((e-1)/4)%4]) begin errors++; $display("FAIL up_seg edge=%0d got=%b want=%b", e, seg, seg_tab[((e-1)/4)%4]); end
        end
    endtask

    task automatic test_sample_down();
        do_reset();
        sample_en = 1'b1; value = 4'd7; dir = 1'b0;
        @(negedge clk);
        sample_en = 1'b0; value = 4'd15; dir = 1'b1;
        seg_tab[0] = S7; seg_tab[1] = BLANK; seg_tab[2] = DOWN; seg_tab[3] = DOWN;
        for (int e = 2; e <= 17; e++) begin
            @(negedge clk);
            checks++; if (an !== an_tab[((e-1)/4)%4]) begin errors++; $display("FAIL down_an edge=%0d got=%b want=%b", e, an, an_tab[((e-1)/4)%4]); end
            checks++; if (seg !== seg_tab[((e-1)/4)%4]) begin errors++; $display("FAIL down_seg edge=%0d got=%b want=%b", e, seg, seg_tab[((e-1)/4)%4]); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        sample_en = 1'b1; value = 4'd13; dir = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        seg_tab[0] = S3; seg_tab[1] = S1; seg_tab[2] = UP; seg_tab[3] = UP;
        for (int e = 2; e <= 17; e++) begin
            value = (e % 2 == 0) ? 4'd5 : 4'd10;
            dir   = ~dir;
            @(negedge clk);
            checks++; if (an !== an_tab[((e-1)/4)%4]) begin errors++; $display("FAIL hold_an edge=%0d got=%b want=%b", e, an, an_tab[((e-1)/4)%4]); end
            checks++; if (seg !== seg_tab[((e-1)/4)%4]) begin errors++; $display("FAIL hold_seg edge=%0d got=%b want=%b", e, seg, seg_tab[((e-1)/4)%4]); end
        end
    endtask

    // Edge 4 is the first idx wrap after reset; the capture lands on that same edge.
    task automatic test_sample_on_wrap();
        do_reset();
        value = 4'd10; dir = 1'b0; sample_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (seg !== S0) begin errors++; $display("FAIL wrap_pre_seg got=%b want=%b", seg, S0); end
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0; value = 4'd3;
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL wrap_edge4_an got=%b want=1110", an); end
        checks++; if (seg !== S0)     begin errors++; $display("FAIL wrap_edge4_seg got=%b want=%b", seg, S0); end
        @(negedge clk);
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL wrap_edge5_an got=%b want=1101", an); end
        checks++; if (seg !== S1)     begin errors++; $display("FAIL wrap_edge5_seg got=%b want=%b", seg, S1); end
        repeat (4) @(negedge clk);
        checks++; if (seg !== DOWN)   begin errors++; $display("FAIL wrap_edge9_seg got=%b want=%b", seg, DOWN); end
        repeat (8) @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL wrap_edge17_an got=%b want=1110", an); end
        checks++; if (seg !== S0)     begin errors++; $display("FAIL wrap_edge17_seg got=%b want=%b", seg, S0); end
    endtask

    task automatic test_async_reset_mid_scan();
        do_reset();
        sample_en = 1'b1; value = 4'd13; dir = 1'b0;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an got=%b want=1011", an); end
        checks++; if (seg !== DOWN)   begin errors++; $display("FAIL mid_pre_seg got=%b want=%b", seg, DOWN); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mid_async_an got=%b want=1111", an); end
        checks++; if (seg !== BLANK)  begin errors++; $display("FAIL mid_async_seg got=%b want=%b", seg, BLANK); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_restart_an got=%b want=1110", an); end
        checks++; if (seg !== S0)     begin errors++; $display("FAIL mid_restart_seg got=%b want=%b", seg, S0); end
        @(negedge clk);
        checks++; if (seg !== S0)     begin errors++; $display("FAIL mid_valq_seg got=%b want=%b", seg, S0); end
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'b1101) begin errors++; $display("FAIL mid_tens_an got=%b want=1101", an); end
        checks++; if (seg !== BLANK)  begin errors++; $display("FAIL mid_tens_seg got=%b want=%b", seg, BLANK); end
        repeat (4) @(negedge clk);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_arrow_an got=%b want=1011", an); end
        checks++; if (seg !== UP)     begin errors++; $display("FAIL mid_arrow_seg got=%b want=%b", seg, UP); end
    endtask

    initial begin
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        test_reset();
        test_sample_up();
        test_sample_down();
        test_hold();
        test_sample_on_wrap();
        test_async_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ping_pong_seven_seg_display.md
Name:
ping_pong_seven_seg_display

Overview:
- Downstream stage of the parameterized ping-pong counter. Consumes its 4-bit count and direction bit and drives a 4-digit, common-anode, active-low seven-segment display by time-multiplexed scanning.
- Digit layout: AN3/AN2 show a direction arrow; AN1/AN0 show the count in decimal (00–15).
- Count and direction are captured into holding registers under a sample strobe, so the displayed value is stable across a full scan.

Parameters:
- REFRESH_DIV, 131072, clock cycles per digit slot (≥2); the digit index advances once per REFRESH_DIV cycles.
- CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_en  input  1  when 1 at a rising edge, capture value/dir into holding registers
- value  input  4  count from the ping-pong counter (unsigned 0–15)
- dir  input  1  direction from the ping-pong counter (1 = counting up, 0 = counting down)
- an  output  4  digit anodes, active-low, registered; an[i]=0 selects digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n (asserting rst_n=0 clears all state immediately, independent of clk).
- Reset values: refresh_cnt=0, idx=0, val_q=0, dir_q=1, an=4'b1111, seg=7'b1111111 (all blank).
- Holding registers:
  - at each rising edge with sample_en=1: val_q<=value, dir_q<=dir;
  - with sample_en=0 they hold;
  - sample_en is independent of scan timing.
- Refresh counter: increments every cycle. At REFRESH_DIV-1 it wraps to 0 and, on the same edge, idx advances 0→1→2→3→0 (2-bit wrap).
- Output pipeline: an/seg are registered from the pre-edge idx, val_q and dir_q, so they lag idx and the holding registers by exactly one cycle. A sample therefore reaches seg at the earliest 2 edges after sample_en is seen.
- Anode decode: idx=i → an has only bit i low. Exactly one anode is low at any time after the first post-reset edge.
- Digit content:
  - idx=0: ones = val_q mod 10;
  - idx=1: tens = 1 if val_q ≥ 10, else blank (seg=7'b1111111) — leading-zero blanking; the anode is still driven;
  - idx=2 and idx=3: arrow from dir_q; up arrow (dir_q=1) = 7'b1011100 (a,b,f lit), down arrow (dir_q=0) = 7'b1100011 (c,d,e lit).
- Digit patterns 0–9:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
- BCD split: purely combinational (val_q−10 when val_q ≥ 10); no divider.
- Simultaneous sample_en and idx wrap: both take effect on the same edge; the next registered seg uses the new idx with the new val_q.
- Reset mid-scan: outputs blank immediately; scan restarts at idx=0 on the first edge after rst_n deasserts.
- No input is ever X-propagated to outputs from the reset state: holding registers are always defined.

Test Plan (bench uses REFRESH_DIV=4, CNT_W=2):
- Reset → an=1111, seg=1111111 during reset. After release: first edge gives an=1110, seg=1000000 ("0"); idx advances every 4 cycles; an cycles 1110→1101→1011→0111→1110.
- sample_en pulse with value=13, dir=1 → over one full scan: digit0 seg=0110000 ("3"), digit1 seg=1111001 ("1"), digits2/3 seg=1011100 (up arrow).
- value=7, dir=0 sampled → digit1 blank (1111111) with an[1]=0; digit0=1111000; digits2/3=1100011.
- sample_en=0 while value/dir toggle every cycle → seg pattern per digit unchanged from the last captured value (e.g., stays "13 up").
- sample_en asserted on the idx wrap edge with value=10 → next seg is from the new idx and the value 10 ("0" on digit0, "1" on digit1); no stale digit is displayed.
- rst_n pulsed low asynchronously mid-slot at idx=2 → an/seg go blank without a clock edge; after release, val_q=0 and dir_q=1 (shows "0", up arrows) and the scan restarts at an=1110.
